decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered, parametrised decode pipeline stage: decodes common::instr_t into operand ids, immediate, mux selects,
//  ALU function and control flags, with valid/ready handshakes on both sides. Adds a per-register pending-write
//  scoreboard (RAW stall), illegal-opcode reporting, serialisation of iret/tlbwrite, and flush. Sits between fetch and
//  the register-read/execute stages; writeback retires scoreboard entries.
// PARAMETERS
//  WORD_W    32  datapath / immediate / PC width; immediate = zero-extended fields.m.immediate
//  REG_N     32  architectural registers; REGID_W = $clog2(REG_N)
//  SB_CNT_W  3   width of each per-register in-flight write counter (max 2**SB_CNT_W-1 outstanding)
// PORTS
//  clk           in   1        clock
//  rst_n         in   1        asynchronous active-low reset
//  in_valid      in   1        fetch presents in_instr/in_pc
//  in_ready      out  1        stage accepts this cycle (combinational)
//  in_instr      in   instr_t  instruction word
//  in_pc         in   WORD_W   PC of in_instr
//  flush         in   1        squash held output and block acceptance this cycle
//  out_valid     out  1        decoded bundle valid
//  out_ready     in   1        downstream consumes bundle
//  out_r1/out_r2/out_dst out REGID_W  source/destination ids
//  out_imm       out  WORD_W   immediate
//  out_a/out_b   out  mux_a_t/mux_b_t  operand selects
//  out_func      out  func_t   ALU function
//  out_flags     out  9        {mem,store,isbyte,mul,reg,jump,branch,iret,illegal}
//  out_tlbwrite  out  tlbwrite_t  off/itlb/dtlb (itlb when fields.b.offset_lo==0)
//  out_pc        out  WORD_W   PC of bundle
//  wb_valid      in   1        a register write retires this cycle
//  wb_dst        in   REGID_W  register retired
//  sb_empty      out  1        all scoreboard counters zero
// BEHAVIOUR
//  Reset: out_valid=0, all out_* fields 0, out_tlbwrite=off, all counters 0; in_ready=1 once rst_n high.
//  Decode table: add/sub (regfile,regfile,reg); mul (mul,reg); ldb/ldw (add,regfile,imm,mem,reg[,isbyte]);
//   stb/stw (add,regfile,imm,mem,store[,isbyte]); beq (add,pc,imm,jump,branch); jump (add,regfile,imm,jump);
//   mov (land,regfile,regfile,reg); tlbwrite (add, tlbwrite); iret (add, iret). Any other opcode: illegal=1,
//   all other flags 0, func=add, a/b=regfile; passes downstream as a normal bundle, no scoreboard update.
//  Sources read: r1+r2 for add,sub,mul,mov,stb,stw,beq,tlbwrite; r1 only for ldb,ldw,jump; none for iret/illegal.
//  Register 0 is never tracked: it never causes a hazard and is never counted.
//  hazard = any read source with counter!=0, OR flag_reg && counter[dst]==max,
//   OR (iret|tlbwrite) && (!sb_empty || out_valid).
//  in_ready = !flush && !hazard && (!out_valid || out_ready). Accept = in_valid && in_ready.
//  Latency 1: on accept, bundle registered; out_valid=1 next cycle. Held stable while out_valid && !out_ready.
//  Handshake complete (out_valid && out_ready && !flush) with no accept -> out_valid=0.
//  Scoreboard counter[r] next = cur + inc - dec_wb - dec_flush, all same cycle:
//   inc = accept of flag_reg instr with dst==r; dec_wb = wb_valid && wb_dst==r;
//   dec_flush = flush && out_valid && held bundle flag_reg && held dst==r.
//  Simultaneous inc and dec on same reg: net unchanged. wb on zero counter is a protocol error: counter holds 0,
//   assertion fires.
//  Flush: out_valid=0 next cycle, held bundle's dst counter decremented, no accept, no transfer even if out_ready=1.
//  Reset mid-operation: all state cleared immediately (async); in-flight writebacks afterwards are ignored at zero.
// TESTING
//  T1 add r3,r1,r2 with out_ready=1 -> next cycle out_valid=1, func=add, flags reg=1; counter[3]=1; wb r3 -> 0.
//  T2 ldw r4,(r1) accepted, then add r5,r4,r2 presented -> in_ready=0 until wb_dst=4; accepted the cycle after wb.
//  T3 out_ready=0 for 3 cycles with new in_valid -> bundle and out_pc stable, in_ready=0; released on out_ready=1.
//  T4 add r6 held, flush=1 -> out_valid=0 next cycle, counter[6] 1->0, incoming instr not accepted that cycle.
//  T5 iret with counter[2]=1 -> stall until wb r2 and out empty; tlbwrite offset_lo=0 -> itlb, offset_lo=1 -> dtlb.
//  T6 undefined opcode -> out_flags illegal=1, others 0; 7 outstanding writes to r7 (SB_CNT_W=3) -> 8th stalls.

Source files
------------

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// common: shared ISA types for the decode pipeline.
//
// Instruction word layout (32 bits): opcode[31:26], then a 26-bit field union.
// All formats keep dst at [25:21] and r1 at [20:16]. r2 sits at [15:11], which
// overlaps the top of the 16-bit immediate, so the decoder can extract every
// operand id and the immediate from fixed positions whatever the opcode.
// -----------------------------------------------------------------------------
package common;

  typedef enum logic [5:0] {
    OP_ADD      = 6'h01,
    OP_SUB      = 6'h02,
    OP_MUL      = 6'h03,
    OP_LDB      = 6'h04,
    OP_LDW      = 6'h05,
    OP_STB      = 6'h06,
    OP_STW      = 6'h07,
    OP_BEQ      = 6'h08,
    OP_JUMP     = 6'h09,
    OP_MOV      = 6'h0A,
    OP_TLBWRITE = 6'h0B,
    OP_IRET     = 6'h0C
  } opcode_t;

  typedef struct packed {
    logic [4:0]  dst;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [10:0] unused;
  } r_fields_t;

  typedef struct packed {
    logic [4:0]  dst;
    logic [4:0]  r1;
    logic [15:0] immediate;
  } m_fields_t;

  typedef struct packed {
    logic [4:0]  dst;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [9:0]  offset_hi;
    logic        offset_lo;
  } b_fields_t;

  typedef union packed {
    r_fields_t r;
    m_fields_t m;
    b_fields_t b;
  } fields_t;

  typedef struct packed {
    opcode_t opcode;
    fields_t fields;
  } instr_t;

  typedef enum logic       {A_REGFILE, A_PC}                 mux_a_t;
  typedef enum logic       {B_REGFILE, B_IMM}                mux_b_t;
  typedef enum logic [1:0] {F_ADD, F_SUB, F_MUL, F_LAND}     func_t;
  typedef enum logic [1:0] {TLB_OFF, TLB_ITLB, TLB_DTLB}     tlbwrite_t;

  // Bit positions inside the 9-bit flag vector
  // {mem,store,isbyte,mul,reg,jump,branch,iret,illegal}.
  localparam int FLAG_ILLEGAL = 0;
  localparam int FLAG_IRET    = 1;
  localparam int FLAG_BRANCH  = 2;
  localparam int FLAG_JUMP    = 3;
  localparam int FLAG_REG     = 4;
  localparam int FLAG_MUL     = 5;
  localparam int FLAG_ISBYTE  = 6;
  localparam int FLAG_STORE   = 7;
  localparam int FLAG_MEM     = 8;

  // Control part of a decoded instruction, plus which sources it reads.
  typedef struct packed {
    func_t     func;
    mux_a_t    a;
    mux_b_t    b;
    logic [8:0] flags;
    tlbwrite_t tlbwrite;
    logic      rd_r1;
    logic      rd_r2;
  } ctrl_t;

  // Pure opcode decode. offset_lo picks the TLB for tlbwrite (0 -> itlb).
  function automatic ctrl_t decode(opcode_t op, logic offset_lo);
    ctrl_t c;
    c.func     = F_ADD;
    c.a        = A_REGFILE;
    c.b        = B_REGFILE;
    c.flags    = '0;
    c.tlbwrite = TLB_OFF;
    c.rd_r1    = 1'b0;
    c.rd_r2    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        c.func            = (op == OP_SUB) ? F_SUB : F_ADD;
        c.flags[FLAG_REG] = 1'b1;
        c.rd_r1           = 1'b1;
        c.rd_r2           = 1'b1;
      end
      OP_MUL: begin
        c.func            = F_MUL;
        c.flags[FLAG_MUL] = 1'b1;
        c.flags[FLAG_REG] = 1'b1;
        c.rd_r1           = 1'b1;
        c.rd_r2           = 1'b1;
      end
      OP_LDB, OP_LDW: begin
        c.b                  = B_IMM;
        c.flags[FLAG_MEM]    = 1'b1;
        c.flags[FLAG_REG]    = 1'b1;
        c.flags[FLAG_ISBYTE] = (op == OP_LDB);
        c.rd_r1              = 1'b1;
      end
      OP_STB, OP_STW: begin
        c.b                  = B_IMM;
        c.flags[FLAG_MEM]    = 1'b1;
        c.flags[FLAG_STORE]  = 1'b1;
        c.flags[FLAG_ISBYTE] = (op == OP_STB);
        c.rd_r1              = 1'b1;
        c.rd_r2              = 1'b1;
      end
      OP_BEQ: begin
        c.a                  = A_PC;
        c.b                  = B_IMM;
        c.flags[FLAG_JUMP]   = 1'b1;
        c.flags[FLAG_BRANCH] = 1'b1;
        c.rd_r1              = 1'b1;
        c.rd_r2              = 1'b1;
      end
      OP_JUMP: begin
        c.b                = B_IMM;
        c.flags[FLAG_JUMP] = 1'b1;
        c.rd_r1            = 1'b1;
      end
      OP_MOV: begin
        c.func            = F_LAND;
        c.flags[FLAG_REG] = 1'b1;
        c.rd_r1           = 1'b1;
        c.rd_r2           = 1'b1;
      end
      OP_TLBWRITE: begin
        c.tlbwrite = offset_lo ? TLB_DTLB : TLB_ITLB;
        c.rd_r1    = 1'b1;
        c.rd_r2    = 1'b1;
      end
      OP_IRET: begin
        c.flags[FLAG_IRET] = 1'b1;
      end
      default: begin
        // Unknown opcode travels downstream as a harmless bundle.
        c.flags[FLAG_ILLEGAL] = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// -----------------------------------------------------------------------------
// decode_stage: registered decode stage with valid/ready on both sides.
//
// Decodes an instr_t into operand ids, zero-extended immediate, operand mux
// selects, ALU function and control flags. A per-register counter of
// in-flight writes stalls readers (RAW) and caps outstanding writes per
// register. iret/tlbwrite wait until the pipeline behind is empty. flush
// drops the held bundle and un-counts its write.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready is combinational)
//   in_instr, in_pc       instruction and its PC
//   flush                 squash held bundle, block acceptance this cycle
//   out_valid/out_ready   downstream handshake
//   out_r1/out_r2/out_dst source/destination register ids
//   out_imm               zero-extended immediate
//   out_a/out_b           operand selects
//   out_func              ALU function
//   out_flags             {mem,store,isbyte,mul,reg,jump,branch,iret,illegal}
//   out_tlbwrite          off/itlb/dtlb
//   out_pc                PC of the held bundle
//   wb_valid, wb_dst      register write retiring this cycle
//   sb_empty              no register has an in-flight write
// -----------------------------------------------------------------------------
module decode_stage
  import common::*;
#(
  parameter int WORD_W   = 32,
  parameter int REG_N    = 32,
  parameter int SB_CNT_W = 3,
  localparam int REGID_W = $clog2(REG_N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  instr_t             in_instr,
  input  logic [WORD_W-1:0]  in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REGID_W-1:0] out_r1,
  output logic [REGID_W-1:0] out_r2,
  output logic [REGID_W-1:0] out_dst,
  output logic [WORD_W-1:0]  out_imm,
  output mux_a_t             out_a,
  output mux_b_t             out_b,
  output func_t              out_func,
  output logic [8:0]         out_flags,
  output tlbwrite_t          out_tlbwrite,
  output logic [WORD_W-1:0]  out_pc,
  input  logic               wb_valid,
  input  logic [REGID_W-1:0] wb_dst,
  output logic               sb_empty
);

  localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  ctrl_t              dec;
  logic [REGID_W-1:0] in_r1;
  logic [REGID_W-1:0] in_r2;
  logic [REGID_W-1:0] in_dst;
  logic [WORD_W-1:0]  in_imm;

  assign dec    = decode(in_instr.opcode, in_instr.fields.b.offset_lo);
  assign in_r1  = REGID_W'(in_instr.fields.r.r1);
  assign in_r2  = REGID_W'(in_instr.fields.r.r2);
  assign in_dst = REGID_W'(in_instr.fields.r.dst);
  assign in_imm = WORD_W'(in_instr.fields.m.immediate);

  // ---------------------------------------------------------------------------
  // Scoreboard: one in-flight write counter per register (r0 stays zero)
  // ---------------------------------------------------------------------------
  logic [SB_CNT_W-1:0] cnt      [REG_N];
  logic [SB_CNT_W-1:0] cnt_next [REG_N];

  always_comb begin
    sb_empty = 1'b1;
    for (int r = 0; r < REG_N; r++) begin
      if (cnt[r] != '0) sb_empty = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection and input handshake
  // ---------------------------------------------------------------------------
  logic hazard;
  logic accept;
  logic serialising;

  assign serialising = dec.flags[FLAG_IRET] || (dec.tlbwrite != TLB_OFF);

  // NOTE: every variable driven in always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    hazard = 1'b0;
    if (dec.rd_r1 && (in_r1 != '0) && (cnt[in_r1] != '0)) hazard = 1'b1;
    if (dec.rd_r2 && (in_r2 != '0) && (cnt[in_r2] != '0)) hazard = 1'b1;
    // A further write to a register whose counter is saturated must wait.
    if (dec.flags[FLAG_REG] && (in_dst != '0) && (cnt[in_dst] == CNT_MAX)) hazard = 1'b1;
    // iret/tlbwrite only issue into a completely drained back end.
    if (serialising && (!sb_empty || out_valid)) hazard = 1'b1;
  end

  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Counter update: +1 on accepted write, -1 on writeback, -1 when a flush
  // drops a held bundle that would have written. All may coincide.
  // ---------------------------------------------------------------------------
  logic flush_drop;
  assign flush_drop = flush && out_valid && out_flags[FLAG_REG] && (out_dst != '0);

  always_comb begin
    for (int r = 0; r < REG_N; r++) begin : g_cnt
      logic                inc;
      logic                dec_wb;
      logic                dec_fl;
      logic [SB_CNT_W+1:0] up;
      logic [SB_CNT_W+1:0] down;
      inc    = accept && dec.flags[FLAG_REG] && (in_dst == REGID_W'(r));
      dec_wb = wb_valid && (wb_dst == REGID_W'(r));
      dec_fl = flush_drop && (out_dst == REGID_W'(r));
      up     = {2'b00, cnt[r]} + (SB_CNT_W + 2)'(inc);
      down   = (SB_CNT_W + 2)'(dec_wb) + (SB_CNT_W + 2)'(dec_fl);
      // A stray writeback on an idle counter clamps at zero.
      if (r == 0)          cnt_next[r] = '0;
      else if (up > down)  cnt_next[r] = SB_CNT_W'(up - down);
      else                 cnt_next[r] = '0;
    end
  end

  // NOTE: the counters are plain flops rather than a RAM macro, so the whole
  // array is reset; a stale count after reset would stall decode forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_N; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < REG_N; r++) cnt[r] <= cnt_next[r];
    end
  end

  // ---------------------------------------------------------------------------
  // Output bundle register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_r1       <= '0;
      out_r2       <= '0;
      out_dst      <= '0;
      out_imm      <= '0;
      out_a        <= A_REGFILE;
      out_b        <= B_REGFILE;
      out_func     <= F_ADD;
      out_flags    <= '0;
      out_tlbwrite <= TLB_OFF;
      out_pc       <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_r1       <= in_r1;
      out_r2       <= in_r2;
      out_dst      <= in_dst;
      out_imm      <= in_imm;
      out_a        <= dec.a;
      out_b        <= dec.b;
      out_func     <= dec.func;
      out_flags    <= dec.flags;
      out_tlbwrite <= dec.tlbwrite;
      out_pc       <= in_pc;
    end else if (flush || out_ready) begin
      // Either the bundle left downstream or it was squashed; the payload
      // registers keep their stale contents behind out_valid=0.
      out_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol check: a writeback must retire a write that is actually counted.
  // ---------------------------------------------------------------------------
  a_wb_not_idle : assert property (@(posedge clk) disable iff (!rst_n)
    !(wb_valid && (wb_dst != '0) && (cnt[wb_dst] == '0)));

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage: directed stimulus for decode_stage. Expected bundles are
// queued when an instruction is accepted; a monitor pops and compares each
// bundle the DUT hands downstream. Handshake/stall behaviour is checked inline.
// -----------------------------------------------------------------------------
module tb_decode_stage;
  import common::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  instr_t      in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_r1, out_r2, out_dst;
  logic [31:0] out_imm;
  mux_a_t      out_a;
  mux_b_t      out_b;
  func_t       out_func;
  logic [8:0]  out_flags;
  tlbwrite_t   out_tlbwrite;
  logic [31:0] out_pc;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic        sb_empty;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r1(out_r1), .out_r2(out_r2), .out_dst(out_dst), .out_imm(out_imm),
    .out_a(out_a), .out_b(out_b), .out_func(out_func), .out_flags(out_flags),
    .out_tlbwrite(out_tlbwrite), .out_pc(out_pc),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  dst;
    logic [31:0] imm;
    mux_a_t      a;
    mux_b_t      b;
    func_t       func;
    logic [8:0]  flags;
    tlbwrite_t   tlb;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(logic [5:0] op, logic [4:0] dst, logic [4:0] r1, logic [15:0] imm);
    instr_t i;
    i.opcode              = opcode_t'(op);
    i.fields.m.dst        = dst;
    i.fields.m.r1         = r1;
    i.fields.m.immediate  = imm;
    return i;
  endfunction

  function automatic instr_t mk_r(logic [5:0] op, logic [4:0] dst, logic [4:0] r1, logic [4:0] r2);
    return mk(op, dst, r1, {r2, 11'b0});
  endfunction

  function automatic exp_t mk_e(logic [4:0] r1, logic [4:0] r2, logic [4:0] dst, logic [31:0] imm,
                                mux_a_t a, mux_b_t b, func_t f, logic [8:0] fl, tlbwrite_t t,
                                logic [31:0] pc);
    exp_t e;
    e.r1 = r1; e.r2 = r2; e.dst = dst; e.imm = imm; e.a = a; e.b = b;
    e.func = f; e.flags = fl; e.tlb = t; e.pc = pc;
    return e;
  endfunction

  // Monitor: compare every bundle that transfers; a flushed bundle is dropped.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (flush) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected bundle", 128'(out_pc), 128'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("bundle", 128'({out_r1, out_r2, out_dst, out_imm, out_a, out_b, out_func,
                                out_flags, out_tlbwrite, out_pc}), 128'(mon_e));
        end
      end
    end
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(instr_t i, logic [31:0] pc, exp_t e);
    bit ok;
    ok       = 1'b0;
    in_instr = i;
    in_pc    = pc;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    check("accept within budget", 128'(ok), 128'(1));
  endtask

  task automatic wb(logic [4:0] r);
    wb_valid = 1'b1;
    wb_dst   = r;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_dst = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst out_valid", 128'(out_valid), 128'(0));
    check("rst out_pc", 128'(out_pc), 128'(0));
    check("rst out_flags", 128'(out_flags), 128'(0));
    check("rst out_tlbwrite", 128'(out_tlbwrite), 128'(TLB_OFF));
    check("rst sb_empty", 128'(sb_empty), 128'(1));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst in_ready", 128'(in_ready), 128'(1));
    tick();

    // T1: add r3,r1,r2
    send(mk_r(6'h01, 3, 1, 2), 32'h100,
         mk_e(1, 2, 3, 32'h1000, A_REGFILE, B_REGFILE, F_ADD, 9'h010, TLB_OFF, 32'h100));
    @(negedge clk);
    check("t1 out_valid", 128'(out_valid), 128'(1));
    check("t1 r3 counted", 128'(sb_empty), 128'(0));
    tick();
    wb(3);
    @(negedge clk);
    check("t1 r3 retired", 128'(sb_empty), 128'(1));
    tick();

    // T2: ldw r4,(r1) then add r5,r4,r2 stalls until wb r4
    send(mk(6'h05, 4, 1, 16'h0040), 32'h104,
         mk_e(1, 0, 4, 32'h40, A_REGFILE, B_IMM, F_ADD, 9'h110, TLB_OFF, 32'h104));
    in_instr = mk_r(6'h01, 5, 4, 2); in_pc = 32'h108; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t2 raw stall", 128'(in_ready), 128'(0));
    end
    tick();
    wb_valid = 1'b1; wb_dst = 4;
    @(negedge clk);
    check("t2 stall in wb cycle", 128'(in_ready), 128'(0));
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("t2 ready after wb", 128'(in_ready), 128'(1));
    exp_q.push_back(mk_e(4, 2, 5, 32'h1000, A_REGFILE, B_REGFILE, F_ADD, 9'h010, TLB_OFF, 32'h108));
    tick();
    in_valid = 1'b0;
    wb(5);

    // T3: back-pressure holds the bundle stable
    out_ready = 1'b0;
    send(mk_r(6'h02, 8, 1, 2), 32'h200,
         mk_e(1, 2, 8, 32'h1000, A_REGFILE, B_REGFILE, F_SUB, 9'h010, TLB_OFF, 32'h200));
    in_instr = mk_r(6'h0A, 9, 1, 3); in_pc = 32'h204; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3 held valid", 128'(out_valid), 128'(1));
      check("t3 held pc", 128'(out_pc), 128'(32'h200));
      check("t3 held dst", 128'(out_dst), 128'(8));
      check("t3 held func", 128'(out_func), 128'(F_SUB));
      check("t3 in_ready", 128'(in_ready), 128'(0));
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("t3 released", 128'(in_ready), 128'(1));
    exp_q.push_back(mk_e(1, 3, 9, 32'h1800, A_REGFILE, B_REGFILE, F_LAND, 9'h010, TLB_OFF, 32'h204));
    tick();
    in_valid = 1'b0;
    wb(8);
    wb(9);
    @(negedge clk);
    check("t3 sb drained", 128'(sb_empty), 128'(1));
    tick();

    // T4: flush drops held add r6 and blocks acceptance
    out_ready = 1'b0;
    send(mk_r(6'h01, 6, 1, 2), 32'h300,
         mk_e(1, 2, 6, 32'h1000, A_REGFILE, B_REGFILE, F_ADD, 9'h010, TLB_OFF, 32'h300));
    @(negedge clk);
    check("t4 r6 counted", 128'(sb_empty), 128'(0));
    tick();
    flush = 1'b1; out_ready = 1'b1;
    in_instr = mk_r(6'h01, 10, 1, 2); in_pc = 32'h304; in_valid = 1'b1;
    @(negedge clk);
    check("t4 flush blocks accept", 128'(in_ready), 128'(0));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("t4 out_valid cleared", 128'(out_valid), 128'(0));
    check("t4 r6 uncounted", 128'(sb_empty), 128'(1));
    tick();

    // T5: iret waits for empty scoreboard; tlbwrite waits for empty output
    send(mk_r(6'h01, 2, 1, 3), 32'h400,
         mk_e(1, 3, 2, 32'h1800, A_REGFILE, B_REGFILE, F_ADD, 9'h010, TLB_OFF, 32'h400));
    in_instr = mk_r(6'h0C, 0, 0, 0); in_pc = 32'h404; in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t5 iret stalls", 128'(in_ready), 128'(0));
    end
    tick();
    wb_valid = 1'b1; wb_dst = 2;
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("t5 iret ready", 128'(in_ready), 128'(1));
    exp_q.push_back(mk_e(0, 0, 0, 32'h0, A_REGFILE, B_REGFILE, F_ADD, 9'h002, TLB_OFF, 32'h404));
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    send(mk_r(6'h0A, 0, 1, 1), 32'h408,
         mk_e(1, 1, 0, 32'h0800, A_REGFILE, B_REGFILE, F_LAND, 9'h010, TLB_OFF, 32'h408));
    @(negedge clk);
    check("t5 r0 untracked", 128'(sb_empty), 128'(1));
    tick();
    in_instr = mk(6'h0B, 0, 1, 16'h0010); in_pc = 32'h40C; in_valid = 1'b1;
    @(negedge clk);
    check("t5 tlbwrite waits", 128'(in_ready), 128'(0));
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("t5 tlbwrite waits out_valid", 128'(in_ready), 128'(0));
    send(mk(6'h0B, 0, 1, 16'h0010), 32'h40C,
         mk_e(1, 0, 0, 32'h10, A_REGFILE, B_REGFILE, F_ADD, 9'h000, TLB_ITLB, 32'h40C));
    send(mk(6'h0B, 0, 1, 16'h0011), 32'h410,
         mk_e(1, 0, 0, 32'h11, A_REGFILE, B_REGFILE, F_ADD, 9'h000, TLB_DTLB, 32'h410));

    // T6: illegal opcode, remaining decode table rows, counter saturation
    send(mk_r(6'h3F, 7, 1, 2), 32'h500,
         mk_e(1, 2, 7, 32'h1000, A_REGFILE, B_REGFILE, F_ADD, 9'h001, TLB_OFF, 32'h500));
    @(negedge clk);
    check("t6 illegal not counted", 128'(sb_empty), 128'(1));
    tick();
    send(mk(6'h04, 12, 1, 16'h0005), 32'h504,
         mk_e(1, 0, 12, 32'h5, A_REGFILE, B_IMM, F_ADD, 9'h150, TLB_OFF, 32'h504));
    send(mk(6'h06, 0, 1, 16'h1803), 32'h508,
         mk_e(1, 3, 0, 32'h1803, A_REGFILE, B_IMM, F_ADD, 9'h1C0, TLB_OFF, 32'h508));
    send(mk(6'h07, 0, 1, 16'h0804), 32'h50C,
         mk_e(1, 1, 0, 32'h0804, A_REGFILE, B_IMM, F_ADD, 9'h180, TLB_OFF, 32'h50C));
    send(mk(6'h08, 0, 1, 16'h1010), 32'h510,
         mk_e(1, 2, 0, 32'h1010, A_PC, B_IMM, F_ADD, 9'h00C, TLB_OFF, 32'h510));
    send(mk(6'h09, 0, 1, 16'h0020), 32'h514,
         mk_e(1, 0, 0, 32'h20, A_REGFILE, B_IMM, F_ADD, 9'h008, TLB_OFF, 32'h514));
    send(mk_r(6'h03, 13, 1, 2), 32'h518,
         mk_e(1, 2, 13, 32'h1000, A_REGFILE, B_REGFILE, F_MUL, 9'h030, TLB_OFF, 32'h518));
    wb(12);
    wb(13);
    for (int k = 0; k < 7; k++) begin
      send(mk_r(6'h01, 7, 0, 0), 32'h600 + 32'(4 * k),
           mk_e(0, 0, 7, 32'h0, A_REGFILE, B_REGFILE, F_ADD, 9'h010, TLB_OFF, 32'h600 + 32'(4 * k)));
    end
    in_instr = mk_r(6'h01, 7, 0, 0); in_pc = 32'h61C; in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t6 8th write stalls", 128'(in_ready), 128'(0));
    end
    tick();
    wb_valid = 1'b1; wb_dst = 7;
    @(negedge clk);
    check("t6 stall in wb cycle", 128'(in_ready), 128'(0));
    tick();
    wb_valid = 1'b0;
    send(mk_r(6'h01, 7, 0, 0), 32'h61C,
         mk_e(0, 0, 7, 32'h0, A_REGFILE, B_REGFILE, F_ADD, 9'h010, TLB_OFF, 32'h61C));
    for (int k = 0; k < 7; k++) wb(7);
    @(negedge clk);
    check("t6 r7 drained", 128'(sb_empty), 128'(1));
    tick();

    // Asynchronous reset in the middle of a held bundle
    out_ready = 1'b0;
    send(mk_r(6'h01, 11, 1, 2), 32'h700,
         mk_e(1, 2, 11, 32'h1000, A_REGFILE, B_REGFILE, F_ADD, 9'h010, TLB_OFF, 32'h700));
    @(negedge clk);
    check("mid-rst r11 counted", 128'(sb_empty), 128'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-rst out_valid", 128'(out_valid), 128'(0));
    check("mid-rst sb_empty", 128'(sb_empty), 128'(1));
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("post-rst in_ready", 128'(in_ready), 128'(1));
    tick();

    repeat (3) tick();
    check("all bundles seen", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
